lru_priority_tracker: RTL and testbench

Produces and maintains the priority_array consumed by the crossbar output-port grant number generator. It closes the arbitration loop with least-recently-granted (LRU) fairness. Each completed transfer moves the granted candidate to the lowest priority slot. Multi-beat transfers are locked so priority cannot change mid-packet. One instance sits beside each output-port arbiter.

---
 rtl/lru_priority_tracker.sv | 157 +++++++++++++++
 tb/tb_lru_priority_tracker.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lru_priority_tracker.sv
// lru_priority_tracker
// Keeps the least-recently-granted priority ordering for one crossbar output
// port. Slot 0 of priority_array is the highest priority candidate. Each
// completed transfer moves its candidate to the lowest priority slot. While a
// multi-beat transfer is in progress the ordering is frozen and only the lock
// owner may continue.
//
// Ports:
//   clk            single clock, all state updates on the rising edge
//   rst_n          asynchronous active-low reset
//   prio_clear     synchronous restore of the reset ordering and lock state
//   grant_valid    one beat of grant_number is accepted downstream this cycle
//   grant_number   index of the granted candidate
//   grant_last     the accepted beat ends the transfer
//   priority_array registered ordering, slot 0 = highest priority
//   lock           registered, a multi-beat transfer is in progress
//   locked_number  registered, owner of the lock (meaningful while lock=1)
//   protocol_err   registered one-cycle pulse per illegal grant event
module lru_priority_tracker #(
    parameter  int candidate = 2,
    localparam int IDW       = $clog2(candidate)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           prio_clear,
    input  logic           grant_valid,
    input  logic [IDW-1:0] grant_number,
    input  logic           grant_last,
    output logic [IDW-1:0] priority_array [0:candidate-1],
    output logic           lock,
    output logic [IDW-1:0] locked_number,
    output logic           protocol_err
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // One extra bit so the candidate count itself is representable.
    localparam logic [IDW:0] CAND_L = (IDW+1)'(candidate);

    state_t         state_r;
    state_t         state_next_s;
    logic [IDW-1:0] owner_r;
    logic [IDW-1:0] owner_next_s;
    logic           err_r;
    logic           err_next_s;
    logic           commit_s;
    logic           legal_s;
    logic           past_s;
    logic [IDW-1:0] prio_r [0:candidate-1];
    logic [IDW-1:0] lru_s  [0:candidate-1];

    // An index is legal only when it names an existing candidate.
    function automatic logic is_legal(input logic [IDW-1:0] idx);
        return ({1'b0, idx} < CAND_L);
    endfunction

    // Next-state, lock owner, error pulse and commit decision.
    always_comb begin
        state_next_s = state_r;
        owner_next_s = owner_r;
        err_next_s   = 1'b0;
        commit_s     = 1'b0;
        legal_s      = is_legal(grant_number);
        if (prio_clear) begin
            // Clear wins; a same-cycle grant is silently discarded.
            state_next_s = IDLE;
            owner_next_s = '0;
        end else if (!grant_valid) begin
            state_next_s = state_r;
        end else if (!legal_s) begin
            err_next_s = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_last) begin
                        commit_s = 1'b1;
                    end else begin
                        state_next_s = LOCKED;
                        owner_next_s = grant_number;
                    end
                end
                LOCKED: begin
                    if (grant_number != owner_r) begin
                        // Interloper: ignored, flagged, lock untouched.
                        err_next_s = 1'b1;
                    end else if (grant_last) begin
                        commit_s     = 1'b1;
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = LOCKED;
                    end
                end
                default: begin
                    state_next_s = IDLE;
                    owner_next_s = '0;
                end
            endcase
        end
    end

    // LRU move-to-back: every slot at or after the granted entry takes its
    // successor, and the last slot receives the granted index. When the
    // granted index is already last the result equals the current array.
    always_comb begin
        past_s = 1'b0;
        for (int i = 0; i < candidate - 1; i++) begin
            past_s   = past_s | (prio_r[i] == grant_number);
            lru_s[i] = past_s ? prio_r[i+1] : prio_r[i];
        end
        lru_s[candidate-1] = grant_number;
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            owner_r <= '0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            owner_r <= owner_next_s;
            err_r   <= err_next_s;
        end
    end

    // Priority ordering register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < candidate; i++) begin
                prio_r[i] <= IDW'(i);
            end
        end else if (prio_clear) begin
            for (int i = 0; i < candidate; i++) begin
                prio_r[i] <= IDW'(i);
            end
        end else if (commit_s) begin
            prio_r <= lru_s;
        end else begin
            prio_r <= prio_r;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        for (int i = 0; i < candidate; i++) begin
            priority_array[i] = prio_r[i];
        end
    end

    assign lock          = (state_r == LOCKED);
    assign locked_number = owner_r;
    assign protocol_err  = err_r;

endmodule

// File: tb/tb_lru_priority_tracker.sv
// Bench for lru_priority_tracker: one instance with 4 candidates, one with 3.
// A driver applies directed and random grant events on the falling edge,
// advances a queue-based ordering model and pushes the expected registered
// outputs; a monitor pops one entry after each rising edge and compares.
module tb_lru_priority_tracker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       c4 = 1'b0, v4 = 1'b0, l4 = 1'b0;
    logic [1:0] n4 = 2'd0;
    logic [1:0] p4 [0:3];
    logic       lk4, e4;
    logic [1:0] w4;

    logic       c3 = 1'b0, v3 = 1'b0, l3 = 1'b0;
    logic [1:0] n3 = 2'd0;
    logic [1:0] p3 [0:2];
    logic       lk3, e3;
    logic [1:0] w3;

    always #5 clk = ~clk;

    lru_priority_tracker #(.candidate(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .prio_clear(c4), .grant_valid(v4),
        .grant_number(n4), .grant_last(l4), .priority_array(p4),
        .lock(lk4), .locked_number(w4), .protocol_err(e4)
    );

    lru_priority_tracker #(.candidate(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .prio_clear(c3), .grant_valid(v3),
        .grant_number(n3), .grant_last(l3), .priority_array(p3),
        .lock(lk3), .locked_number(w3), .protocol_err(e3)
    );

    typedef struct packed {
        logic [3:0][1:0] o4;
        logic            l4;
        logic [1:0]      w4;
        logic            e4;
        logic [2:0][1:0] o3;
        logic            l3;
        logic [1:0]      w3;
        logic            e3;
    } exp_t;

    exp_t exp_q [$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: ordering kept as "least recently granted first".
    int m_ord  [2][4];
    bit m_lock [2];
    int m_own  [2];
    bit m_err  [2];
    int m_n    [2] = '{4, 3};

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) m_ord[k][i] = i;
            m_lock[k] = 1'b0;
            m_own[k]  = 0;
            m_err[k]  = 1'b0;
        end
    endtask

    task automatic grant_done(input int k, input int g);
        int q [$];
        int idx;
        idx = -1;
        for (int i = 0; i < m_n[k]; i++) q.push_back(m_ord[k][i]);
        foreach (q[i]) if (q[i] == g) idx = i;
        if (idx >= 0) begin
            q.delete(idx);
            q.push_back(g);
        end
        for (int i = 0; i < m_n[k]; i++) m_ord[k][i] = q[i];
    endtask

    task automatic model_step(input int k, input bit v, input int num,
                              input bit last, input bit clr);
        m_err[k] = 1'b0;
        if (clr) begin
            for (int i = 0; i < 4; i++) m_ord[k][i] = i;
            m_lock[k] = 1'b0;
            m_own[k]  = 0;
        end else if (v) begin
            if (num >= m_n[k]) begin
                m_err[k] = 1'b1;
            end else if (m_lock[k] && num != m_own[k]) begin
                m_err[k] = 1'b1;
            end else if (last) begin
                grant_done(k, num);
                m_lock[k] = 1'b0;
            end else if (!m_lock[k]) begin
                m_lock[k] = 1'b1;
                m_own[k]  = num;
            end
        end
    endtask

    function automatic exp_t pack_exp();
        exp_t e;
        for (int i = 0; i < 4; i++) e.o4[i] = 2'(m_ord[0][i]);
        for (int i = 0; i < 3; i++) e.o3[i] = 2'(m_ord[1][i]);
        e.l4 = m_lock[0]; e.w4 = 2'(m_own[0]); e.e4 = m_err[0];
        e.l3 = m_lock[1]; e.w3 = 2'(m_own[1]); e.e3 = m_err[1];
        return e;
    endfunction

    // One event per DUT on the falling edge; expectation queued for after the edge.
    task automatic step(input bit va, input int na, input bit la, input bit ca,
                        input bit vb, input int nb, input bit lb, input bit cb);
        @(negedge clk);
        v4 = va; n4 = 2'(na); l4 = la; c4 = ca;
        v3 = vb; n3 = 2'(nb); l3 = lb; c3 = cb;
        model_step(0, va, na, la, ca);
        model_step(1, vb, nb, lb, cb);
        exp_q.push_back(pack_exp());
    endtask

    task automatic step4(input bit v, input int n, input bit l, input bit c);
        step(v, n, l, c, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic step3(input bit v, input int n, input bit l, input bit c);
        step(1'b0, 0, 1'b0, 1'b0, v, n, l, c);
    endtask

    // Monitor: compare after each rising edge, and check the permutation property.
    always @(posedge clk) begin
        exp_t            e;
        logic [3:0][1:0] a4;
        logic [2:0][1:0] a3;
        int              seen;
        #1;
        for (int i = 0; i < 4; i++) a4[i] = p4[i];
        for (int i = 0; i < 3; i++) a3[i] = p3[i];
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("prio4", int'(a4), int'(e.o4));
            check("lock4", int'(lk4), int'(e.l4));
            check("err4", int'(e4), int'(e.e4));
            if (e.l4) check("owner4", int'(w4), int'(e.w4));
            check("prio3", int'(a3), int'(e.o3));
            check("lock3", int'(lk3), int'(e.l3));
            check("err3", int'(e3), int'(e.e3));
            if (e.l3) check("owner3", int'(w3), int'(e.w3));
        end
        seen = 0;
        for (int i = 0; i < 4; i++) seen = seen | (1 << p4[i]);
        check("perm4", seen, 15);
        seen = 0;
        for (int i = 0; i < 3; i++) seen = seen | (1 << p3[i]);
        check("perm3", seen, 7);
    end

    initial begin
        int n, l;
        logic [3:0][1:0] a4;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        for (int i = 0; i < 4; i++) a4[i] = p4[i];
        check("rst_prio4", int'(a4), int'(8'b11_10_01_00));
        check("rst_lock4", int'(lk4), 0);
        check("rst_err4", int'(e4), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle cycle, then single-beat grants 1, 0, 3.
        step4(1'b0, 0, 1'b0, 1'b0);
        step4(1'b1, 1, 1'b1, 1'b0);
        step4(1'b1, 0, 1'b1, 1'b0);
        step4(1'b1, 3, 1'b1, 1'b0);

        // Three-beat transfer by 2 with an interloper between beats.
        step4(1'b0, 0, 1'b0, 1'b1);
        step4(1'b1, 2, 1'b0, 1'b0);
        step4(1'b1, 0, 1'b1, 1'b0);
        step4(1'b1, 1, 1'b0, 1'b0);
        step4(1'b1, 2, 1'b0, 1'b0);
        step4(1'b1, 2, 1'b1, 1'b0);
        step4(1'b0, 0, 1'b0, 1'b0);

        // Build {3,2,1,0}, lock on 1, then clear together with a grant of 0.
        step4(1'b1, 2, 1'b1, 1'b0);
        step4(1'b1, 1, 1'b1, 1'b0);
        step4(1'b1, 0, 1'b1, 1'b0);
        step4(1'b1, 1, 1'b0, 1'b0);
        step4(1'b1, 0, 1'b1, 1'b1);
        step4(1'b0, 0, 1'b0, 1'b0);

        // Three candidates: out-of-range index, then grant of the last slot,
        // then back-to-back out-of-range events.
        step3(1'b0, 0, 1'b0, 1'b1);
        step3(1'b1, 3, 1'b1, 1'b0);
        step3(1'b1, 2, 1'b1, 1'b0);
        step3(1'b1, 3, 1'b0, 1'b0);
        step3(1'b1, 3, 1'b1, 1'b0);
        step3(1'b0, 0, 1'b0, 1'b0);

        // Random soak with an asynchronous reset in the middle of a lock.
        for (int c = 0; c < 10000; c++) begin
            if (c == 5000) begin
                step(1'b1, m_lock[0] ? m_own[0] : 1, 1'b0, 1'b0,
                     1'b1, m_lock[1] ? m_own[1] : 2, 1'b0, 1'b0);
                @(posedge clk);
                #3;
                rst_n = 1'b0;
                v4 = 1'b0; v3 = 1'b0; c4 = 1'b0; c3 = 1'b0;
                #1;
                for (int i = 0; i < 4; i++) a4[i] = p4[i];
                check("arst_lock4", int'(lk4), 0);
                check("arst_lock3", int'(lk3), 0);
                check("arst_prio4", int'(a4), int'(8'b11_10_01_00));
                check("arst_err", int'(e4 | e3), 0);
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                int na, nb;
                na = (m_lock[0] && $urandom_range(0, 4) != 0) ? m_own[0] : int'($urandom_range(0, 3));
                nb = (m_lock[1] && $urandom_range(0, 4) != 0) ? m_own[1] : int'($urandom_range(0, 3));
                n = int'($urandom_range(0, 9));
                l = int'($urandom_range(0, 1));
                step(n < 7, na, l[0], $urandom_range(0, 63) == 0,
                     $urandom_range(0, 9) < 7, nb, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 63) == 0);
            end
        end

        step(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
